j1_wb_uart: RTL

Wishbone slave UART for the J1 system: it answers the 16-bit bus that the J1 CPU drives as master, and provides a serial 8N1 transmitter and receiver. Software reaches it with plain `@` and `!` accesses. The block sits behind the system address decoder, which asserts `stb` only for this block's window. Each bus request is acknowledged exactly one cycle later, matching the CPU's synchronous-read timing.

---
 rtl/j1_wb_uart_pkg.sv | 24 ++
 rtl/if_wb.sv | 15 +
 rtl/j1_wb_uart_sync_fifo.sv | 50 +++++
 rtl/j1_wb_uart.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/j1_wb_uart_pkg.sv
// j1_wb_uart_pkg: shared register map, STATUS bit positions and the UART
// bit-level state type used by both the TX and RX machines.
package j1_wb_uart_pkg;

  typedef enum logic [1:0] {
    UART_DATA   = 2'd0,
    UART_STATUS = 2'd1,
    UART_DIV    = 2'd2
  } uart_reg_t;

  localparam int ST_RX_VALID   = 0;
  localparam int ST_TX_READY   = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_TX_BUSY    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/if_wb.sv
// if_wb: 16-bit data / 16-bit word-address Wishbone bus between the J1 and its peripherals.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (output cyc, stb, we, adr, dat_i, input dat_o, ack, err, rty);
  modport slave  (input cyc, stb, we, adr, dat_i, output dat_o, ack, err, rty);
endinterface

// File: rtl/j1_wb_uart_sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read data.
// A pop frees a slot for a push on the same edge even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s, do_pop_s;

  assign empty     = (count_r == (AW+1)'(0));
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign rd_data   = mem_r[rd_ptr_r];

  // pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // storage array
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
  end
endmodule

// File: rtl/j1_wb_uart.sv
// j1_wb_uart: Wishbone slave 8N1 UART for the J1 system.
// Define J1_WB_UART_RXFIFO_EN to use an RX_DEPTH-entry RX FIFO instead of a single holding register.
module j1_wb_uart
  import j1_wb_uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter int          RX_DEPTH    = 8
) (
  input  logic clk,
  input  logic reset,
  if_wb.slave  wb,
  input  logic uart_rxd,
  output logic uart_txd,
  output logic irq
);
  logic        req_s, wr_s, rd_s, status_rd_s;
  logic [1:0]  reg_adr_s;
  logic [15:0] div_r, period_s, status_s;
  logic        ack_r;
  logic [15:0] dat_o_r;
  logic        overrun_r, frame_err_r;
  logic [13:0] adr_unused_s;

  uart_state_t tx_state_r;
  logic [15:0] tx_cnt_r;
  logic [2:0]  tx_bit_r;
  logic [7:0]  tx_shift_r, tx_hold_r;
  logic        tx_full_r, txd_r;

  uart_state_t rx_state_r;
  logic        rxd_s1_r, rxd_s2_r, rxd_prev_r;
  logic [15:0] rx_cnt_r;
  logic [2:0]  rx_bit_r;
  logic [7:0]  rx_shift_r, rx_front_s;
  logic        stop_sample_s, rx_push_s, ferr_set_s, ovr_set_s;
  logic        rx_pop_s, rx_full_s, rx_valid_s;

  assign req_s         = wb.cyc & wb.stb;
  assign wr_s          = req_s & wb.we;
  assign rd_s          = req_s & ~wb.we;
  assign reg_adr_s     = wb.adr[1:0];
  assign adr_unused_s  = wb.adr[15:2];
  assign status_rd_s   = rd_s && (reg_adr_s == UART_STATUS);
  assign period_s      = (div_r < 16'd2) ? 16'd2 : div_r;
  assign stop_sample_s = (rx_state_r == STOP) && (rx_cnt_r == 16'd0);
  assign rx_push_s     = stop_sample_s & rxd_s2_r;
  assign ferr_set_s    = stop_sample_s & ~rxd_s2_r;
  assign rx_pop_s      = rd_s && (reg_adr_s == UART_DATA) && rx_valid_s;
  assign ovr_set_s     = rx_push_s & rx_full_s & ~rx_pop_s;

  // STATUS word assembly
  always_comb begin
    status_s                = 16'h0000;
    status_s[ST_RX_VALID]   = rx_valid_s;
    status_s[ST_TX_READY]   = ~tx_full_r;
    status_s[ST_RX_OVERRUN] = overrun_r;
    status_s[ST_FRAME_ERR]  = frame_err_r;
    status_s[ST_TX_BUSY]    = (tx_state_r != IDLE);
  end

  // bus response, DIV register and sticky error flags (a set beats a clearing read)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_r       <= 1'b0;
      dat_o_r     <= 16'h0000;
      div_r       <= DEFAULT_DIV;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      ack_r <= req_s;
      if (rd_s) begin
        case (reg_adr_s)
          UART_DATA:   dat_o_r <= rx_valid_s ? {1'b1, 7'b0000000, rx_front_s} : 16'h0000;
          UART_STATUS: dat_o_r <= status_s;
          UART_DIV:    dat_o_r <= div_r;
          default:     dat_o_r <= 16'h0000;
        endcase
      end else begin
        dat_o_r <= 16'h0000;
      end
      if (wr_s && (reg_adr_s == UART_DIV)) div_r <= wb.dat_i;
      overrun_r   <= ovr_set_s  | (overrun_r   & ~status_rd_s);
      frame_err_r <= ferr_set_s | (frame_err_r & ~status_rd_s);
    end
  end

  // TX holding register and frame machine; txd lags the state by one clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_r <= IDLE;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx_hold_r  <= 8'h00;
      tx_full_r  <= 1'b0;
      txd_r      <= 1'b1;
    end else begin
      if (wr_s && (reg_adr_s == UART_DATA) && !tx_full_r) begin
        tx_hold_r <= wb.dat_i[7:0];
        tx_full_r <= 1'b1;
      end else if (tx_full_r && ((tx_state_r == IDLE) ||
                                 ((tx_state_r == STOP) && (tx_cnt_r == 16'd0)))) begin
        tx_full_r <= 1'b0;
      end
      case (tx_state_r)
        IDLE: begin
          txd_r <= 1'b1;
          if (tx_full_r) begin
            tx_shift_r <= tx_hold_r;
            tx_cnt_r   <= period_s - 16'd1;
            tx_state_r <= START;
          end
        end
        START: begin
          txd_r <= 1'b0;
          if (tx_cnt_r == 16'd0) begin
            tx_cnt_r   <= period_s - 16'd1;
            tx_bit_r   <= 3'd0;
            tx_state_r <= DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r - 16'd1;
          end
        end
        DATA: begin
          txd_r <= tx_shift_r[0];
          if (tx_cnt_r == 16'd0) begin
            tx_cnt_r   <= period_s - 16'd1;
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            tx_bit_r   <= tx_bit_r + 3'd1;
            if (tx_bit_r == 3'd7) tx_state_r <= STOP;
          end else begin
            tx_cnt_r <= tx_cnt_r - 16'd1;
          end
        end
        STOP: begin
          txd_r <= 1'b1;
          if (tx_cnt_r == 16'd0) begin
            if (tx_full_r) begin
              tx_shift_r <= tx_hold_r;
              tx_cnt_r   <= period_s - 16'd1;
              tx_state_r <= START;
            end else begin
              tx_state_r <= IDLE;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r - 16'd1;
          end
        end
        default: tx_state_r <= IDLE;
      endcase
    end
  end

  // RX synchronizer and frame machine, sampling mid-bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_s1_r   <= 1'b1;
      rxd_s2_r   <= 1'b1;
      rxd_prev_r <= 1'b1;
      rx_state_r <= IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      rxd_s1_r   <= uart_rxd;
      rxd_s2_r   <= rxd_s1_r;
      rxd_prev_r <= rxd_s2_r;
      case (rx_state_r)
        IDLE: begin
          if (rxd_prev_r && !rxd_s2_r) begin
            rx_cnt_r   <= (period_s >> 1) - 16'd1;
            rx_state_r <= START;
          end
        end
        START: begin
          if (rx_cnt_r == 16'd0) begin
            if (rxd_s2_r) begin
              rx_state_r <= IDLE;
            end else begin
              rx_cnt_r   <= period_s - 16'd1;
              rx_bit_r   <= 3'd0;
              rx_state_r <= DATA;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r - 16'd1;
          end
        end
        DATA: begin
          if (rx_cnt_r == 16'd0) begin
            rx_shift_r <= {rxd_s2_r, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 3'd1;
            rx_cnt_r   <= period_s - 16'd1;
            if (rx_bit_r == 3'd7) rx_state_r <= STOP;
          end else begin
            rx_cnt_r <= rx_cnt_r - 16'd1;
          end
        end
        STOP: begin
          if (rx_cnt_r == 16'd0) rx_state_r <= IDLE;
          else                   rx_cnt_r   <= rx_cnt_r - 16'd1;
        end
        default: rx_state_r <= IDLE;
      endcase
    end
  end

`ifdef J1_WB_UART_RXFIFO_EN
  logic fifo_empty_s;

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rx_push_s),
    .pop     (rx_pop_s),
    .wr_data (rx_shift_r),
    .rd_data (rx_front_s),
    .full    (rx_full_s),
    .empty   (fifo_empty_s)
  );
  assign rx_valid_s = ~fifo_empty_s;
`else
  logic        rx_hold_full_r;
  logic [7:0]  rx_hold_r;
  logic [31:0] rx_depth_unused_s;

  assign rx_depth_unused_s = 32'(RX_DEPTH);

  // single-entry RX store; a same-edge pop frees the slot for the incoming byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_hold_full_r <= 1'b0;
      rx_hold_r      <= 8'h00;
    end else if (rx_push_s && (!rx_hold_full_r || rx_pop_s)) begin
      rx_hold_full_r <= 1'b1;
      rx_hold_r      <= rx_shift_r;
    end else if (rx_pop_s) begin
      rx_hold_full_r <= 1'b0;
    end
  end
  assign rx_full_s  = rx_hold_full_r;
  assign rx_valid_s = rx_hold_full_r;
  assign rx_front_s = rx_hold_r;
`endif

  assign wb.ack   = ack_r;
  assign wb.dat_o = dat_o_r;
  assign wb.err   = 1'b0;
  assign wb.rty   = 1'b0;
  assign uart_txd = txd_r;
  assign irq      = rx_valid_s;
endmodule
